divizor_frecventa_multi: RTL

- Parametrised successor to the fixed 1 Hz / 20 kHz divider.
- Provides N_CH independent divider channels from the 100 MHz system clock. Each channel produces a square clock and a one-cycle tick pulse.
- Each channel's divisor is reprogrammable at runtime through a write port. Changes are applied glitch-free at the channel's wrap boundary.
- Feeds the intersection controller timers (1 Hz) and the display multiplex (20 kHz) from one block.

---
 rtl/divizor_pkg.sv | 14 +
 rtl/divizor_canal.sv | 76 +++++++
 rtl/divizor_frecventa_multi.sv | 83 ++++++++
 3 files changed

// File: rtl/divizor_pkg.sv
// Shared constants and helpers for the multi-channel frequency divider.
// Pulled in by divizor_canal and divizor_frecventa_multi.
package divizor_pkg;

  localparam int DIV_MIN   = 2;
  localparam int DIV_1HZ   = 100000000;
  localparam int DIV_20KHZ = 5000;

  // Channel-select width; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/divizor_canal.sv
// One divider channel: counter, active and shadow divisor, pending flag,
// and registered square-clock / tick outputs.
module divizor_canal
  import divizor_pkg::*;
#(
  parameter int             CNT_W    = 27,
  parameter logic [CNT_W-1:0] DIV_INIT = CNT_W'(DIV_1HZ)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic             wr_i,
  input  logic [CNT_W-1:0] wr_div_i,
  output logic             pend_o,
  output logic             clk_o,
  output logic             tick_o
);

  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic [CNT_W-1:0] div_reg, div_next;
  logic [CNT_W-1:0] shadow_reg, shadow_next;
  logic             pend_reg, pend_next;
  logic             clk_reg, clk_next;
  logic             tick_reg, tick_next;
  logic             wrap;
  logic             apply;

  always_comb begin
    wrap        = en_i & (cnt_reg >= (div_reg - CNT_W'(1)));
    // A disabled channel has no wrap to wait for, so it takes the new value at once.
    apply       = pend_reg & (wrap | ~en_i | sync_i);

    cnt_next    = cnt_reg + CNT_W'(1);
    if (~en_i | sync_i | wrap) begin
      cnt_next = '0;
    end

    div_next    = apply ? shadow_reg : div_reg;
    shadow_next = wr_i ? wr_div_i : shadow_reg;

    // Writes are only accepted while not pending, so wr_i and apply never coincide.
    pend_next   = pend_reg;
    if (wr_i) begin
      pend_next = 1'b1;
    end else if (apply) begin
      pend_next = 1'b0;
    end

    clk_next    = en_i & (cnt_reg < (div_reg >> 1));
    tick_next   = wrap & ~sync_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_reg    <= '0;
      div_reg    <= DIV_INIT;
      shadow_reg <= DIV_INIT;
      pend_reg   <= 1'b0;
      clk_reg    <= 1'b0;
      tick_reg   <= 1'b0;
    end else begin
      cnt_reg    <= cnt_next;
      div_reg    <= div_next;
      shadow_reg <= shadow_next;
      pend_reg   <= pend_next;
      clk_reg    <= clk_next;
      tick_reg   <= tick_next;
    end
  end

  assign pend_o = pend_reg;
  assign clk_o  = clk_reg;
  assign tick_o = tick_reg;

endmodule

// File: rtl/divizor_frecventa_multi.sv
// N_CH independent, runtime-reprogrammable clock dividers with write decode.
// Define DIVIZOR_SYNC_EN to add the sync_i phase-alignment input.
module divizor_frecventa_multi
  import divizor_pkg::*;
#(
  parameter int                      N_CH      = 2,
  parameter int                      CNT_W     = 27,
  parameter logic [N_CH*CNT_W-1:0]   DIV_RESET = {CNT_W'(DIV_20KHZ), CNT_W'(DIV_1HZ)},
  localparam int                     CH_W      = ch_width(N_CH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [N_CH-1:0]  en_i,
  input  logic             cfg_we_i,
  input  logic [CH_W-1:0]  cfg_ch_i,
  input  logic [CNT_W-1:0] cfg_div_i,
  output logic             cfg_ready_o,
  output logic             cfg_err_o,
  output logic [N_CH-1:0]  clk_o,
  output logic [N_CH-1:0]  tick_o
`ifdef DIVIZOR_SYNC_EN
  ,
  input  logic             sync_i
`endif
);

  logic                   sync_w;
  logic [N_CH-1:0]        pend_w;
  logic [(1<<CH_W)-1:0]   pend_pad;
  logic [N_CH-1:0]        wr_sel;
  logic                   ch_legal;
  logic                   div_legal;
  logic                   accept;
  logic                   err_reg, err_next;

`ifdef DIVIZOR_SYNC_EN
  assign sync_w = sync_i;
`else
  assign sync_w = 1'b0;
`endif

  // Unused select codes read as "not pending" so an out-of-range channel reaches the error path.
  always_comb begin
    pend_pad             = '0;
    pend_pad[N_CH-1:0]   = pend_w;
  end

  assign cfg_ready_o = ~pend_pad[cfg_ch_i];
  assign ch_legal    = (int'(cfg_ch_i) < N_CH);
  assign div_legal   = (cfg_div_i >= CNT_W'(DIV_MIN));
  assign accept      = cfg_we_i & cfg_ready_o & ch_legal & div_legal;
  assign err_next    = cfg_we_i & cfg_ready_o & ~(ch_legal & div_legal);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign cfg_err_o = err_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign wr_sel[gi] = accept & (cfg_ch_i == CH_W'(gi));

    divizor_canal #(
      .CNT_W    (CNT_W),
      .DIV_INIT (DIV_RESET[gi*CNT_W +: CNT_W])
    ) u_canal (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .en_i     (en_i[gi]),
      .sync_i   (sync_w),
      .wr_i     (wr_sel[gi]),
      .wr_div_i (cfg_div_i),
      .pend_o   (pend_w[gi]),
      .clk_o    (clk_o[gi]),
      .tick_o   (tick_o[gi])
    );
  end

endmodule
